// File: rtl/scale_sched.sv
// Sequencer, parameter table and credit-tracked output FIFO for the requantization (scale) unit.
// Optional stall counter enabled by defining SCALE_SCHED_PERF_EN.
module scale_sched #(
  parameter int DW     = 22,
  parameter int DN     = 6,
  parameter int MULW   = 9,
  parameter int OW     = 8,
  parameter int GRPS   = 16,
  parameter int LAT    = 4,
  parameter int FDEPTH = 8,
  localparam int AW    = $clog2(GRPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [DN*MULW-1:0]   cfg_mul,
  input  logic [4:0]           cfg_n,
  input  logic [1:0]           cfg_relu,
  input  logic                 start,
  input  logic [AW:0]          num_grp,
  input  logic [15:0]          num_pix,
  output logic                 busy,
  output logic                 done,
  input  logic [DN*DW-1:0]     acc_data,
  input  logic                 acc_valid,
  output logic                 acc_ready,
  output logic [DN*DW-1:0]     sc_m_data1,
  output logic                 sc_m_valid1,
  output logic [DN*MULW-1:0]   sc_m_data2,
  output logic [4:0]           sc_n,
  output logic [1:0]           sc_relu_en,
  input  logic [DN*OW-1:0]     sc_s_data,
  input  logic                 sc_s_valid,
  output logic [DN*OW-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          perf_stall
);

  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW = $clog2(FDEPTH + LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t state, state_nxt;

  logic [DN*MULW-1:0] mul_tab  [GRPS];
  logic [4:0]         n_tab    [GRPS];
  logic [1:0]         relu_tab [GRPS];

  logic [AW:0]        num_grp_q;
  logic [15:0]        num_pix_q;
  logic [AW-1:0]      grp;
  logic [15:0]        pix;
  logic               done_q;

  logic [LAT-1:0]     trk_p;
  logic [CW-1:0]      inflight_cnt;

  logic [DN*OW-1:0]   fifo_mem [FDEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      fifo_cnt;
  logic               fifo_empty, fifo_full, fifo_push, fifo_pop;

  logic               accept, credit_ok, last_grp, last_pix, drained;

  function automatic logic [CW-1:0] popcnt(input logic [LAT-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < LAT; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign inflight_cnt = popcnt(trk_p);
  assign fifo_empty   = (fifo_cnt == '0);
  assign fifo_full    = (fifo_cnt == CW'(FDEPTH));
  assign fifo_push    = sc_s_valid;
  assign fifo_pop     = out_valid && out_ready;

  // Credit covers beats already in the scale pipeline plus those parked in the FIFO.
  assign credit_ok = (inflight_cnt + fifo_cnt) < CW'(FDEPTH);
  assign acc_ready = (state == S_RUN) && credit_ok;
  assign accept    = acc_valid && acc_ready;

  assign last_grp = ({1'b0, grp} == num_grp_q - 1'b1);
  assign last_pix = (pix == num_pix_q - 16'd1);
  assign drained  = (inflight_cnt == '0) && fifo_empty;

  assign sc_m_valid1 = accept;
  assign sc_m_data1  = acc_data;
  assign sc_m_data2  = mul_tab[grp];
  assign sc_n        = n_tab[grp];
  assign sc_relu_en  = relu_tab[grp];

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = done_q;
    case (state)
      S_IDLE: begin
        if (start && (num_grp != '0) && (num_pix != '0)) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (accept && last_grp && last_pix) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drained) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      done_q    <= 1'b0;
      num_grp_q <= '0;
      num_pix_q <= '0;
      grp       <= '0;
      pix       <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == S_IDLE) && start && ((num_grp == '0) || (num_pix == '0));
      if ((state == S_IDLE) && start) begin
        num_grp_q <= num_grp;
        num_pix_q <= num_pix;
        grp       <= '0;
        pix       <= '0;
      end else if (accept) begin
        if (last_grp) begin
          grp <= '0;
          pix <= pix + 16'd1;
        end else begin
          grp <= grp + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < GRPS; i++) begin
        mul_tab[i]  <= '0;
        n_tab[i]    <= '0;
        relu_tab[i] <= '0;
      end
    end else if (cfg_we && (state == S_IDLE)) begin
      mul_tab[cfg_addr]  <= cfg_mul;
      n_tab[cfg_addr]    <= cfg_n;
      relu_tab[cfg_addr] <= cfg_relu;
    end
  end

  // Issue flags shadow the scale pipeline; the top bit lines up with sc_s_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_p    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      trk_p <= (trk_p << 1) | LAT'(sc_m_valid1);
      if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= sc_s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(fifo_push && fifo_full && !fifo_pop));
  end

`ifdef SCALE_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst || ((state == S_IDLE) && start)) begin
      perf_q <= '0;
    end else if ((state == S_RUN) && acc_valid && !acc_ready) begin
      perf_q <= sat_inc(perf_q);
    end
  end

  assign perf_stall = perf_q;
`else
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_scale_sched.sv
// Bench for scale_sched: behavioural scale unit plus scoreboard of expected result beats.
module tb_scale_sched;

  localparam int DW = 22, DN = 6, MULW = 9, OW = 8, GRPS = 16, LAT = 4, FDEPTH = 8, AW = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [DN*MULW-1:0] cfg_mul;
  logic [4:0]         cfg_n;
  logic [1:0]         cfg_relu;
  logic               start;
  logic [AW:0]        num_grp;
  logic [15:0]        num_pix;
  logic               busy, done;
  logic [DN*DW-1:0]   acc_data;
  logic               acc_valid, acc_ready;
  logic [DN*DW-1:0]   sc_m_data1;
  logic               sc_m_valid1;
  logic [DN*MULW-1:0] sc_m_data2;
  logic [4:0]         sc_n;
  logic [1:0]         sc_relu_en;
  logic [DN*OW-1:0]   sc_s_data;
  logic               sc_s_valid;
  logic [DN*OW-1:0]   out_data;
  logic               out_valid, out_ready;
  logic [31:0]        perf_stall;

  always #5 clk = ~clk;

  scale_sched dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mul(cfg_mul),
    .cfg_n(cfg_n), .cfg_relu(cfg_relu), .start(start), .num_grp(num_grp), .num_pix(num_pix),
    .busy(busy), .done(done), .acc_data(acc_data), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .sc_m_data1(sc_m_data1), .sc_m_valid1(sc_m_valid1), .sc_m_data2(sc_m_data2), .sc_n(sc_n),
    .sc_relu_en(sc_relu_en), .sc_s_data(sc_s_data), .sc_s_valid(sc_s_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .perf_stall(perf_stall)
  );

  function automatic logic [DN*OW-1:0] scale_f(input logic [DN*DW-1:0] d, input logic [DN*MULW-1:0] m,
                                               input logic [4:0] n, input logic [1:0] r);
    logic [DN*OW-1:0] o;
    for (int i = 0; i < DN; i++) o[i*OW +: OW] = d[i*DW +: 8] ^ m[i*MULW +: 8] ^ {r, 1'b0, n};
    return o;
  endfunction

  // Behavioural scale unit: fixed LAT-cycle pipe, reset from the same source.
  logic [DN*OW-1:0] sp_d [LAT];
  logic [LAT-1:0]   sp_v;
  always @(posedge clk) begin
    if (rst) sp_v <= '0;
    else     sp_v <= {sp_v[LAT-2:0], sc_m_valid1};
    sp_d[0] <= scale_f(sc_m_data1, sc_m_data2, sc_n, sc_relu_en);
    for (int k = 1; k < LAT; k++) sp_d[k] <= sp_d[k-1];
  end
  assign sc_s_valid = sp_v[LAT-1];
  assign sc_s_data  = sp_d[LAT-1];

  logic [DN*MULW-1:0] tb_mul  [GRPS];
  logic [4:0]         tb_n    [GRPS];
  logic [1:0]         tb_relu [GRPS];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, st_cyc = 0, done_cyc = -1;
  int acc_cnt = 0, pop_cnt = 0, done_cnt = 0, scv_cnt = 0;
  int beats_left = 0, mgrp = 0;
  int acc_cyc[$];
  int pop_cyc[$];
  logic [4:0] acc_n[$];
  logic [DN*OW-1:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DN*DW-1:0] rnd_beat();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[DN*DW-1:0];
  endfunction

  function automatic logic [DN*MULW-1:0] rnd_mul();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DN*MULW-1:0];
  endfunction

  // One clock: sample at the falling edge, drive just after the rising edge.
  task automatic tick();
    logic hs, pp;
    logic [DN*OW-1:0] e;
    @(negedge clk);
    hs = acc_valid && acc_ready;
    pp = out_valid && out_ready;
    if (sc_m_valid1) scv_cnt++;
    if (hs) begin
      chk("params", 64'({sc_relu_en, sc_n, sc_m_data2}), 64'({tb_relu[mgrp], tb_n[mgrp], tb_mul[mgrp]}));
      sb.push_back(scale_f(acc_data, tb_mul[mgrp], tb_n[mgrp], tb_relu[mgrp]));
      acc_cyc.push_back(cyc);
      acc_n.push_back(sc_n);
      acc_cnt++;
      mgrp = (mgrp == int'(num_grp) - 1) ? 0 : mgrp + 1;
    end
    if (pp) begin
      if (sb.size() == 0) begin
        chk("out_valid_unexpected", 64'(out_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e));
      end
      pop_cyc.push_back(cyc);
      pop_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", 64'(busy), 64'(0));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      beats_left--;
      acc_data = rnd_beat();
    end
    acc_valid = (beats_left > 0);
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  task automatic cfg_write(input int a, input logic [DN*MULW-1:0] m, input logic [4:0] n,
                           input logic [1:0] r, input bit upd);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_mul = m; cfg_n = n; cfg_relu = r;
    tick();
    cfg_we = 1'b0;
    if (upd) begin
      tb_mul[a] = m; tb_n[a] = n; tb_relu[a] = r;
    end
  endtask

  task automatic do_start(input int g, input int p);
    num_grp = 5'(g); num_pix = 16'(p); start = 1'b1; mgrp = 0; st_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic offer(input int k);
    beats_left = k;
    acc_data   = rnd_beat();
    acc_valid  = (k > 0);
  endtask

  task automatic wait_done(input int lim);
    int b, i;
    b = done_cnt; i = 0;
    while (done_cnt == b && i < lim) begin
      tick();
      i++;
    end
    chk("done_seen", 64'(done_cnt - b), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ab, pb, db, sb0, exp_perf;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_mul = '0; cfg_n = '0; cfg_relu = '0;
    start = 1'b0; num_grp = '0; num_pix = '0; acc_valid = 1'b0; acc_data = '0; out_ready = 1'b1;
    for (int i = 0; i < GRPS; i++) begin tb_mul[i] = '0; tb_n[i] = '0; tb_relu[i] = '0; end
    run(3);
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_acc_ready", 64'(acc_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_perf", 64'(perf_stall), 64'(0));

    // Single group, 4 back-to-back beats.
    cfg_write(0, {DN{9'd1}}, 5'd8, 2'b00, 1'b1);
    do_start(1, 4);
    ab = acc_cnt; pb = pop_cnt; db = done_cnt; sb0 = scv_cnt;
    offer(4);
    wait_done(100);
    chk("t1_accepts", 64'(acc_cnt - ab), 64'(4));
    chk("t1_sc_valid_cycles", 64'(scv_cnt - sb0), 64'(4));
    chk("t1_back_to_back", 64'(acc_cyc[ab+3] - acc_cyc[ab]), 64'(3));
    chk("t1_latency", 64'(pop_cyc[pb] - acc_cyc[ab]), 64'(LAT + 1));
    chk("t1_pops", 64'(pop_cnt - pb), 64'(4));
    chk("t1_done_after_pop", 64'(done_cyc - pop_cyc[pb+3]), 64'(1));
    chk("t1_busy_end", 64'(busy), 64'(0));

    // Three groups, two pixels: parameters follow the group counter.
    cfg_write(0, rnd_mul(), 5'd8, 2'b00, 1'b1);
    cfg_write(1, rnd_mul(), 5'd9, 2'b10, 1'b1);
    cfg_write(2, rnd_mul(), 5'd10, 2'b11, 1'b1);
    do_start(3, 2);
    ab = acc_cnt;
    offer(6);
    wait_done(100);
    chk("t2_accepts", 64'(acc_cnt - ab), 64'(6));
    for (int i = 0; i < 6; i++) chk($sformatf("t2_sc_n%0d", i), 64'(acc_n[ab+i]), 64'(8 + (i % 3)));

    // Output blocked: credit limits acceptance to the FIFO depth.
    out_ready = 1'b0;
    do_start(2, 10);
    ab = acc_cnt; pb = pop_cnt;
    offer(20);
    run(30);
    chk("t3_accepts_blocked", 64'(acc_cnt - ab), 64'(FDEPTH));
    chk("t3_acc_ready_low", 64'(acc_ready), 64'(0));
    chk("t3_out_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    wait_done(400);
    chk("t3_accepts_all", 64'(acc_cnt - ab), 64'(20));
    chk("t3_pops_all", 64'(pop_cnt - pb), 64'(20));

    // Empty jobs finish without issuing.
    for (int z = 0; z < 2; z++) begin
      db = done_cnt; sb0 = scv_cnt;
      if (z == 0) do_start(2, 0); else do_start(0, 5);
      chk($sformatf("t4_busy%0d", z), 64'(busy), 64'(0));
      run(3);
      chk($sformatf("t4_done_cnt%0d", z), 64'(done_cnt - db), 64'(1));
      chk($sformatf("t4_done_cyc%0d", z), 64'(done_cyc - st_cyc), 64'(1));
      chk($sformatf("t4_no_issue%0d", z), 64'(scv_cnt - sb0), 64'(0));
    end

    // Table write while busy is ignored.
    do_start(2, 2);
    chk("t5_busy", 64'(busy), 64'(1));
    cfg_write(1, rnd_mul(), 5'd31, 2'b01, 1'b0);
    offer(4);
    wait_done(100);

    // Reset in the middle of a job with results still buffered.
    out_ready = 1'b0;
    do_start(1, 10);
    offer(3);
    run(8);
    chk("t6_busy_before_rst", 64'(busy), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    beats_left = 0; acc_valid = 1'b0;
    for (int i = 0; i < GRPS; i++) begin tb_mul[i] = '0; tb_n[i] = '0; tb_relu[i] = '0; end
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_out_valid", 64'(out_valid), 64'(0));
    chk("t6_out_data", 64'(out_data), 64'(0));
    chk("t6_acc_ready", 64'(acc_ready), 64'(0));
    out_ready = 1'b1;
    do_start(GRPS, 1);
    ab = acc_cnt; pb = pop_cnt;
    offer(GRPS);
    wait_done(200);
    chk("t6_accepts", 64'(acc_cnt - ab), 64'(GRPS));
    chk("t6_pops", 64'(pop_cnt - pb), 64'(GRPS));

    // Stall counter: 8 accepts, then 10 stalled cycles.
`ifdef SCALE_SCHED_PERF_EN
    exp_perf = 10;
`else
    exp_perf = 0;
`endif
    out_ready = 1'b0;
    do_start(1, 10);
    offer(10);
    run(18);
    chk("t7_perf_stall", 64'(perf_stall), 64'(exp_perf));
    out_ready = 1'b1;
    wait_done(200);
    do_start(1, 0);
    run(2);
    chk("t7_perf_clear", 64'(perf_stall), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/scale_sched.md
Name: scale_sched

Overview:
- Sequencer and parameter store for the requantization (scale) unit that follows the accumulator.
- Holds a per-channel-group table of lane multipliers, shift amount and relu mode.
- Streams accumulator beats into the scale unit with the matching group's parameters.
- The scale unit has a fixed 4-cycle latency and no stall input, so this block tracks in-flight beats against an output FIFO so downstream backpressure never drops results.

Parameters:
- DW, 22, accumulator lane width
- DN, 6, lanes per beat
- MULW, 9, multiplier width per lane
- OW, 8, output lane width
- GRPS, 16, max channel groups in table (address width AW = clog2(GRPS))
- LAT, 4, scale-unit latency: issue cycle to s_valid
- FDEPTH, 8, output FIFO depth; must be at least LAT

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  AW  table entry index
- cfg_mul  in  DN*MULW  lane multipliers for the entry
- cfg_n  in  5  shift amount for the entry
- cfg_relu  in  2  relu mode for the entry (0x none, 10 relu, 11 leaky)
- start  in  1  job start pulse
- num_grp  in  AW+1  groups per pixel, 1..GRPS
- num_pix  in  16  pixels in the job
- busy  out  1  job active
- done  out  1  one-cycle pulse at job completion
- acc_data  in  DN*DW  accumulator beat
- acc_valid  in  1  beat valid
- acc_ready  out  1  beat accepted when valid and ready are both high
- sc_m_data1  out  DN*DW  to scale unit m_data1
- sc_m_valid1  out  1  to scale unit m_valid1
- sc_m_data2  out  DN*MULW  to scale unit m_data2
- sc_n  out  5  to scale unit n
- sc_relu_en  out  2  to scale unit relu_en
- sc_s_data  in  DN*OW  from scale unit
- sc_s_valid  in  1  from scale unit
- out_data  out  DN*OW  result beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- perf_stall  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset (sync, rst high at a clk edge):
  - State IDLE; busy, done, acc_ready, out_valid all 0.
  - FIFO emptied; in-flight tracker cleared; grp and pix counters 0; all table entries 0.
  - out_data is 0 while FIFO is empty.
- Table:
  - Register array written on cfg_we in IDLE only; cfg_we while busy is ignored.
  - Read is combinational, indexed by the grp counter.
- FSM IDLE:
  - start loads num_grp and num_pix.
  - If either is 0: done pulses on the next cycle and the state stays IDLE.
  - Otherwise: next state RUN, busy = 1.
  - start while busy is ignored.
- FSM RUN:
  - acc_ready = (inflight_cnt + fifo_cnt < FDEPTH), registered-free combinational.
  - On acceptance: sc_m_valid1 = 1 and sc_m_data1 = acc_data, combinational pass-through.
  - Same cycle: sc_m_data2, sc_n and sc_relu_en = table[grp].
  - When not issuing: sc_m_valid1 = 0, and the parameter outputs still show table[grp].
  - grp increments per accepted beat and wraps to 0 after num_grp-1; pix increments on the wrap.
  - After the beat with grp = num_grp-1 and pix = num_pix-1 is accepted: next state DRAIN.
- FSM DRAIN:
  - acc_ready = 0.
  - When inflight_cnt = 0 and FIFO is empty: done pulses for 1 cycle, busy drops in the same cycle, next state IDLE.
- In-flight tracker:
  - LAT-bit shift register of issue flags; inflight_cnt = popcount.
  - The tracker's output bit aligns with sc_s_valid.
  - sc_s_valid always writes the FIFO. The credit rule guarantees no overflow; overflow is an assertion failure.
- FIFO:
  - FDEPTH entries, first-word fall-through; out_valid = not empty.
  - A pop on out_valid and out_ready, together with a push in the same cycle, is legal when full or empty.
  - Order is preserved: output beats appear in acceptance order.
- Latency: beat accepted at cycle t gives out_valid at t+LAT+1 when the FIFO is empty and out_ready is high.
- Reset mid-job: all state discarded immediately; beats still in the scale pipeline after reset are dropped because the tracker and FIFO are cleared. The scale unit is reset from the same source.

Optional Feature:
- Macro: SCALE_SCHED_PERF_EN.
- When defined:
  - perf_stall counts cycles in RUN with acc_valid = 1 and acc_ready = 0.
  - Cleared on rst and on accepted start; saturates at all ones.
- When undefined: perf_stall is tied to 0 and no counter logic exists.

Test Plan:
- Load table entry 0 with mul = 1 per lane, n = 8, relu = 00; num_grp = 1, num_pix = 4; feed 4 beats back-to-back with out_ready = 1 -> sc_m_valid1 high for 4 cycles with sc_n = 8, out_valid for 4 beats starting 5 cycles after the first acceptance, done 1 cycle after the last pop.
- num_grp = 3, num_pix = 2, entries 0/1/2 with n = 8/9/10 -> the sc_n sequence over 6 beats is 8, 9, 10, 8, 9, 10.
- out_ready = 0 throughout, 20 beats offered -> exactly 8 accepted, acc_ready low afterwards, FIFO full with no overflow; raise out_ready -> the remaining 12 are accepted and all 20 outputs arrive in order.
- start with num_pix = 0 -> done pulses on the next cycle, busy stays 0, no sc_m_valid1.
- cfg_we to entry 1 while busy -> the table is unchanged; after reset asserted mid-job, busy = 0, out_valid = 0 and every table entry reads 0.
- With SCALE_SCHED_PERF_EN, 10 stall cycles -> perf_stall = 10; without the macro -> perf_stall = 0.
